// File: rtl/store_buffer.sv
// Store buffer for the MEM stage: builds byte masks, queues and coalesces
// same-word stores, drains them over req/gnt and flags load/store word hazards.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [2:0]       st_funct3,
  output logic             mem_req,
  input  logic             mem_gnt,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_we,
  input  logic             ld_check_valid,
  input  logic [31:0]      ld_check_addr,
  output logic             ld_hazard,
  output logic [PTR_W:0]   count,
  output logic             empty
);
  localparam logic [2:0]     FNC_SB   = 3'b000;
  localparam logic [2:0]     FNC_SH   = 3'b001;
  localparam logic [2:0]     FNC_SW   = 3'b010;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] TWO_CNT  = (PTR_W+1)'(2);

  logic [29:0]      r_wa   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [3:0]       r_mask [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic [PTR_W-1:0] w_newest;
  logic [3:0]       w_mask;
  logic             w_legal, w_merge_hit, w_merge, w_enq, w_deq;
  logic [31:0]      w_merge_data;
  logic [DEPTH-1:0] w_hit;
  logic             w_unused;

  always_comb begin
    w_mask  = '0;
    w_legal = 1'b1;
    case (st_funct3)
      FNC_SB:  w_mask = 4'b0001 << st_addr[1:0];
      FNC_SH:  w_mask = st_addr[1] ? 4'b1100 : 4'b0011;
      FNC_SW:  w_mask = 4'b1111;
      default: w_legal = 1'b0;
    endcase
  end

  // With count>=2 the newest entry is never the head, so merging cannot
  // disturb data under an outstanding request.
  assign w_newest    = r_wr_ptr - PTR_W'(1);
  assign w_merge_hit = st_valid && (r_count >= TWO_CNT) && (st_addr[31:2] == r_wa[w_newest]);
  assign st_ready    = (r_count < FULL_CNT) || w_merge_hit;
  assign w_merge     = w_merge_hit && w_legal;
  assign w_enq       = st_valid && st_ready && w_legal && !w_merge_hit;
  assign w_deq       = (r_count != '0) && mem_gnt;

  always_comb begin
    w_merge_data = r_data[w_newest];
    for (int b = 0; b < 4; b++)
      if (w_mask[b]) w_merge_data[b*8 +: 8] = st_data[b*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_wa[i]   <= '0;
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_wa[r_wr_ptr]   <= st_addr[31:2];
        r_data[r_wr_ptr] <= st_data;
        r_mask[r_wr_ptr] <= w_mask;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_merge) begin
        r_data[w_newest] <= w_merge_data;
        r_mask[w_newest] <= r_mask[w_newest] | w_mask;
      end
      if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign mem_req   = !empty;
  assign mem_addr  = empty ? '0 : {r_wa[r_rd_ptr], 2'b00};
  assign mem_wdata = empty ? '0 : r_data[r_rd_ptr];
  assign mem_we    = empty ? '0 : r_mask[r_rd_ptr];

  // An entry is occupied when its distance from the head is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] w_ofs;
    assign w_ofs    = PTR_W'(i) - r_rd_ptr;
    assign w_hit[i] = ({1'b0, w_ofs} < r_count) && (r_wa[i] == ld_check_addr[31:2]);
  end

  assign ld_hazard = ld_check_valid && (|w_hit);
  assign w_unused  = ^ld_check_addr[1:0];
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             st_valid, st_ready;
  logic [31:0]      st_addr, st_data;
  logic [2:0]       st_funct3;
  logic             mem_req, mem_gnt;
  logic [31:0]      mem_addr, mem_wdata;
  logic [3:0]       mem_we;
  logic             ld_check_valid, ld_hazard;
  logic [31:0]      ld_check_addr;
  logic [PTR_W:0]   count;
  logic             empty;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_funct3(st_funct3),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .ld_check_valid(ld_check_valid), .ld_check_addr(ld_check_addr),
    .ld_hazard(ld_hazard), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] mdl_mask(input logic [2:0] f, input logic [31:0] a);
    case (f)
      3'd0:    return 4'(1 << a[1:0]);
      3'd1:    return a[1] ? 4'hC : 4'h3;
      3'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  // One cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f, input logic g);
    int   sz;
    logic merge, ready, legal, hz;
    logic [3:0] mk;
    ent_t e;
    st_valid = v; st_addr = a; st_data = d; st_funct3 = f; mem_gnt = g;
    #1;
    sz    = q.size();
    merge = v && (sz >= 2) && (a[31:2] == q[sz-1].wa);
    ready = (sz < DEPTH) || merge;
    legal = (f <= 3'd2);
    mk    = mdl_mask(f, a);
    hz    = 1'b0;
    foreach (q[i]) if (q[i].wa == ld_check_addr[31:2]) hz = 1'b1;
    chk("st_ready", st_ready, ready);
    chk("mem_req",  mem_req, sz != 0);
    chk("mem_addr", mem_addr, sz != 0 ? {q[0].wa, 2'b00} : 32'h0);
    chk("mem_wdata", mem_wdata, sz != 0 ? q[0].d : 32'h0);
    chk("mem_we",   mem_we, sz != 0 ? q[0].m : 4'h0);
    chk("ld_hazard", ld_hazard, ld_check_valid && hz);
    chk("count",    count, sz);
    chk("empty",    empty, sz == 0);
    if (merge && legal) begin
      e = q[sz-1];
      for (int b = 0; b < 4; b++) if (mk[b]) e.d[b*8 +: 8] = d[b*8 +: 8];
      e.m = e.m | mk;
      q[sz-1] = e;
    end
    if (sz > 0 && g) void'(q.pop_front());
    if (v && ready && legal && !merge) begin
      e.wa = a[31:2]; e.d = d; e.m = mk;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic g);
    step(1'b0, 32'h0, 32'h0, 3'd0, g);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_mem_we", mem_we, 4'h0);
    chk("rst_empty", empty, 1'b1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 0; st_addr = 0; st_data = 0; st_funct3 = 0;
    mem_gnt = 0; ld_check_valid = 1; ld_check_addr = 0;
    repeat (2) @(negedge clk);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_mem_we", mem_we, 4'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_ld_hazard", ld_hazard, 1'b0);
    chk("reset_empty", empty, 1'b1);
    chk("reset_st_ready", st_ready, 1'b1);
    rst_n = 1'b1;
    ld_check_valid = 0;
    @(negedge clk);

    // 1: single SB drains with gnt held
    step(1, 32'h1003, 32'hAB000000, 3'd0, 1);
    chk("t1_mem_req", mem_req, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h1000);
    chk("t1_mem_we", mem_we, 4'b1000);
    chk("t1_mem_wdata", mem_wdata, 32'hAB000000);
    idle(1);
    chk("t1_empty", empty, 1'b1);

    // 2: two halfwords in one word do not merge while count<2
    step(1, 32'h2002, 32'hBEEF0000, 3'd1, 0);
    step(1, 32'h2000, 32'h0000CAFE, 3'd1, 0);
    step(1, 32'h3000, 32'h12345678, 3'd2, 0);
    chk("t2_count", count, 3);
    chk("t2_head_we", mem_we, 4'b1100);
    repeat (3) idle(1);
    chk("t2_empty", empty, 1'b1);

    // 3: fill, reject a new word, merge into the newest
    for (int i = 0; i < 4; i++) step(1, 32'h10 + 4*i, $urandom, 3'd2, 0);
    chk("t3_count_full", count, 4);
    step(1, 32'h20, 32'h55555555, 3'd2, 0);
    chk("t3_count_after_reject", count, 4);
    st_valid = 1; st_addr = 32'h1D; st_data = 32'h0000FF00; st_funct3 = 3'd0; #1;
    chk("t3_merge_ready", st_ready, 1'b1);
    step(1, 32'h1D, 32'h0000FF00, 3'd0, 0);
    chk("t3_count_merge", count, 4);

    // 4: gnt pulse while full, store accepted the next cycle
    step(1, 32'h40, 32'hA5A5A5A5, 3'd2, 1);
    chk("t4_count_deq", count, 3);
    step(1, 32'h40, 32'hA5A5A5A5, 3'd2, 0);
    chk("t4_count_refill", count, 4);
    chk("t4_head", mem_addr, 32'h14);
    repeat (4) idle(1);
    chk("t4_empty", empty, 1'b1);

    // 5: load hazard, word-granular, held through gnt cycle
    step(1, 32'h80, 32'hDEADBEEF, 3'd2, 0);
    ld_check_valid = 1; ld_check_addr = 32'h83; #1;
    chk("t5_hz_hit", ld_hazard, 1'b1);
    idle(0);
    ld_check_addr = 32'h84; #1;
    chk("t5_hz_miss", ld_hazard, 1'b0);
    idle(0);
    ld_check_addr = 32'h83; #1;
    chk("t5_hz_gnt", ld_hazard, 1'b1);
    idle(1);
    chk("t5_hz_clear", ld_hazard, 1'b0);
    idle(0);
    ld_check_valid = 0;

    // 6: async reset mid-drain, then an illegal funct3 is swallowed
    step(1, 32'h200, 32'h1, 3'd2, 0);
    step(1, 32'h300, 32'h2, 3'd2, 0);
    step(1, 32'h400, 32'h3, 3'd2, 0);
    chk("t6_count_pre", count, 3);
    mid_reset();
    step(1, 32'h500, 32'h4, 3'b011, 0);
    chk("t6_count_illegal", count, 0);

    // Random traffic over a small address window to exercise merges and hazards
    for (int n = 0; n < 2000; n++) begin
      logic [2:0]  f;
      int          r, gp;
      gp = ((n / 50) % 2 == 0) ? 30 : 80;
      r  = $urandom_range(0, 9);
      f  = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
      ld_check_valid = 1'($urandom_range(0, 1));
      ld_check_addr  = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 7,
           32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
           $urandom, f, $urandom_range(0, 99) < gp);
      if (n == 1000) mid_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
